pipe_ctrl_unit: RTL and testbench
=================================

Name: pipe_ctrl_unit

Overview:
- Pipelined successor to the single-cycle control unit.
- Decodes op/funct in ID, then carries the control bundle through ID/EX, EX/MEM and MEM/WB registers.
- Supports bubble insertion on stall or flush, and resolves branches in EX.
- Tracks a multi-cycle multiply/divide unit with a busy counter and raises a structural-hazard stall for dependent instructions.

Parameters:
- ALU_CONT_W, 3: ALU control width.
- EXT_CONT_W, 4: extension control width.
- MD_LATENCY, 4: busy cycles of mult/div after it leaves EX; legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- op_d  in  6  opcode in ID
- funct_d  in  6  funct in ID
- hazard_stall  in  1  data-hazard stall from the hazard unit
- flush_e  in  1  force a bubble into EX
- zero_e  in  1  ALU zero flag in EX
- stall_d  out  1  hazard_stall | md_stall; holds PC and IF/ID
- jump_sel_d  out  1  j/jal decoded in ID
- pc_src_sel_e  out  1  branch_e & zero_e
- flush_d  out  1  pc_src_sel_e; kills IF/ID
- alu_src_e, reg_dst_sel_e, jal_sel_e  out  1 each  EX controls
- alu_cont_e  out  ALU_CONT_W  ALU control
- ext_cont_e  out  EXT_CONT_W  extension control
- mem_write_m, reg_write_m, mem_to_reg_sel_m  out  1 each  MEM controls
- reg_write_w, mem_to_reg_sel_w, jal_sel_w  out  1 each  WB controls
- md_busy  out  1  mult/div in progress

Behaviour:
- Decode is combinational in ID:
  - R-type 000000: reg_write=1, reg_dst=1, ALU from funct.
  - lw 100011: alu_src=1, mem_to_reg=1, reg_write=1, add.
  - sw 101011: alu_src=1, mem_write=1, add.
  - beq 000100: branch=1, sub.
  - addi 001000: alu_src=1, reg_write=1, add.
  - j 000010: jump=1.
  - jal 000011: jump=1, jal=1, reg_write=1.
  - Any other opcode decodes to an all-zero bundle (NOP).
- ALU codes from funct:
  - add 100000 -> 010, sub 100010 -> 110, and 100100 -> 000, or 100101 -> 001, slt 101010 -> 111.
  - Unknown funct -> 010.
- ext_cont codes:
  - 0 none, 1 mult (011000), 2 div (011010), 3 mfhi (010000), 4 mflo (010010).
  - mfhi/mflo set reg_write=1, reg_dst=1.
  - mult/div set reg_write=0.
- All outputs are registered per stage except stall_d, jump_sel_d, pc_src_sel_e and flush_d.
- Reset: every stage register, md_busy and the busy counter go to 0, so all stage outputs read 0. Reset mid-operation abandons any mult/div in flight.
- ID/EX loads a bubble (all zeros) when stall_d or flush_e is high, otherwise the decoded bundle. EX/MEM and MEM/WB always advance.
- A bubble in EX never asserts pc_src_sel_e.
- Taken branch: pc_src_sel_e=1 and flush_d=1 in the same cycle. The hazard unit drives flush_e on the next edge, which is outside this block.
- md counter:
  - Loads MD_LATENCY on the edge where ext_cont_e is 1 or 2.
  - Decrements to 0 otherwise.
  - md_busy = (count != 0).
- md_stall = md_busy & (ext_cont of the ID decode is in {1,2,3,4}).
- A mult in EX with a dependent mfhi in ID: the counter is still 0 that cycle, so md_stall is 0. The counter loads at that edge and mfhi enters EX. The MD unit forwards its result for this case.
- A new mult/div entering EX while the counter is nonzero cannot happen, because ID is stalled. The counter is reloaded defensively anyway.
- Latency: the decoded bundle appears on the _e outputs 1 cycle after ID, on _m after 2 and on _w after 3.

Optional Feature:
- Macro MD_UNIT_EN.
- Defined: mult/div/mfhi/mflo are decoded, and the busy counter and md_stall are active.
- Undefined: those funct codes decode as NOP (ext_cont 0, reg_write 0), md_busy is tied 0, md_stall is 0, and the counter is not instantiated.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_JAL);
  - funct constants;
  - ALU code constants;
  - EXT code constants;
  - packed struct ctrl_bundle_t with fields alu_src, reg_dst, jal, alu_cont, ext_cont, mem_write, reg_write, mem_to_reg, branch, jump.
- One sub-module md_busy_ctr holds the counter and busy logic. Decode stays inline as combinational logic.

Test Plan:
- Reset asserted mid-stream with lw in EX -> all _e/_m/_w outputs 0 immediately; md_busy=0.
- lw (100011) at ID in cycle 0 -> cycle 1: alu_src_e=1, alu_cont_e=010. Cycle 2: reg_write_m=1, mem_to_reg_sel_m=1. Cycle 3: reg_write_w=1, mem_to_reg_sel_w=1.
- beq in EX with zero_e=1 -> pc_src_sel_e=1, flush_d=1. With zero_e=0 -> both 0. beq with flush_e=1 in the load cycle -> a bubble, and pc_src_sel_e stays 0.
- mult reaches EX, MD_LATENCY=4, mflo held in ID -> md_busy high for 4 cycles; stall_d=1 in busy cycles 1-4; mflo enters EX as ext_cont_e=4 on the cycle after the count reaches 0.
- hazard_stall=1 for 2 cycles with R-type add in ID -> 2 bubbles (all _e outputs 0), then alu_cont_e=010 and reg_dst_sel_e=1.
- With MD_UNIT_EN undefined: R-type funct 011000 -> reg_write_e path 0, ext_cont_e=0, md_busy stays 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and control bundles for the pipelined control unit.
// Mult/div decode is compiled in only when MD_UNIT_EN is defined.
package pipe_ctrl_pkg;

   localparam int ALU_W = 3;
   localparam int EXT_W = 4;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [5:0] F_ADD  = 6'b100000;
   localparam logic [5:0] F_SUB  = 6'b100010;
   localparam logic [5:0] F_AND  = 6'b100100;
   localparam logic [5:0] F_OR   = 6'b100101;
   localparam logic [5:0] F_SLT  = 6'b101010;
   localparam logic [5:0] F_MULT = 6'b011000;
   localparam logic [5:0] F_DIV  = 6'b011010;
   localparam logic [5:0] F_MFHI = 6'b010000;
   localparam logic [5:0] F_MFLO = 6'b010010;

   localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
   localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
   localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
   localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
   localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

   localparam logic [EXT_W-1:0] EXT_NONE = 4'd0;
   localparam logic [EXT_W-1:0] EXT_MULT = 4'd1;
   localparam logic [EXT_W-1:0] EXT_DIV  = 4'd2;
   localparam logic [EXT_W-1:0] EXT_MFHI = 4'd3;
   localparam logic [EXT_W-1:0] EXT_MFLO = 4'd4;

   typedef struct packed {
      logic             alu_src;
      logic             reg_dst;
      logic             jal;
      logic [ALU_W-1:0] alu_cont;
      logic [EXT_W-1:0] ext_cont;
      logic             mem_write;
      logic             reg_write;
      logic             mem_to_reg;
      logic             branch;
      logic             jump;
   } ctrl_bundle_t;

   // Jump is consumed in ID, so later stages carry only what they use.
   typedef struct packed {
      logic             alu_src;
      logic             reg_dst;
      logic             jal;
      logic [ALU_W-1:0] alu_cont;
      logic [EXT_W-1:0] ext_cont;
      logic             mem_write;
      logic             reg_write;
      logic             mem_to_reg;
      logic             branch;
   } ex_ctrl_t;

   typedef struct packed {
      logic jal;
      logic mem_write;
      logic reg_write;
      logic mem_to_reg;
   } mem_ctrl_t;

   typedef struct packed {
      logic jal;
      logic reg_write;
      logic mem_to_reg;
   } wb_ctrl_t;

   function automatic logic [ALU_W-1:0] alu_of_funct(input logic [5:0] f);
      case (f)
         F_ADD:   return ALU_ADD;
         F_SUB:   return ALU_SUB;
         F_AND:   return ALU_AND;
         F_OR:    return ALU_OR;
         F_SLT:   return ALU_SLT;
         default: return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/pipe_ctrl_unit_md_busy_ctr.sv
// Busy counter for the multi-cycle mult/div unit.
// Instantiated only when MD_UNIT_EN is defined.
module md_busy_ctr #(
   parameter int unsigned LATENCY = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic start_i,
   output logic busy_o
);

   logic [3:0] cnt_q;
   logic [3:0] cnt_d;

   // A restart reloads even if busy; ID stalling normally prevents it.
   always_comb begin
      cnt_d = cnt_q;
      if (start_i) begin
         cnt_d = 4'(LATENCY);
      end else if (cnt_q != 4'd0) begin
         cnt_d = cnt_q - 4'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign busy_o = (cnt_q != 4'd0);

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: ID decode, ID/EX, EX/MEM, MEM/WB control regs.
// Define MD_UNIT_EN to enable mult/div decode and structural stall.
module pipe_ctrl_unit
   import pipe_ctrl_pkg::*;
#(
   parameter int ALU_CONT_W = ALU_W,
   parameter int EXT_CONT_W = EXT_W,
   parameter int MD_LATENCY = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [5:0]            op_d,
   input  logic [5:0]            funct_d,
   input  logic                  hazard_stall,
   input  logic                  flush_e,
   input  logic                  zero_e,
   output logic                  stall_d,
   output logic                  jump_sel_d,
   output logic                  pc_src_sel_e,
   output logic                  flush_d,
   output logic                  alu_src_e,
   output logic                  reg_dst_sel_e,
   output logic                  jal_sel_e,
   output logic [ALU_CONT_W-1:0] alu_cont_e,
   output logic [EXT_CONT_W-1:0] ext_cont_e,
   output logic                  mem_write_m,
   output logic                  reg_write_m,
   output logic                  mem_to_reg_sel_m,
   output logic                  reg_write_w,
   output logic                  mem_to_reg_sel_w,
   output logic                  jal_sel_w,
   output logic                  md_busy
);

   if (MD_LATENCY < 1 || MD_LATENCY > 15) begin : g_bad_lat
      $error("MD_LATENCY must be in 1..15");
   end

   ctrl_bundle_t dec;
   ex_ctrl_t     id_ex_d, id_ex_q;
   mem_ctrl_t    ex_mem_d, ex_mem_q;
   wb_ctrl_t     mem_wb_d, mem_wb_q;
   logic         md_stall;

   always_comb begin
      dec = '0;
      case (op_d)
         OP_RTYPE: begin
            dec.reg_write = 1'b1;
            dec.reg_dst   = 1'b1;
            dec.alu_cont  = alu_of_funct(funct_d);
            case (funct_d)
`ifdef MD_UNIT_EN
               F_MULT: begin
                  dec.ext_cont  = EXT_MULT;
                  dec.reg_write = 1'b0;
               end
               F_DIV: begin
                  dec.ext_cont  = EXT_DIV;
                  dec.reg_write = 1'b0;
               end
               F_MFHI: dec.ext_cont = EXT_MFHI;
               F_MFLO: dec.ext_cont = EXT_MFLO;
`else
               F_MULT, F_DIV, F_MFHI, F_MFLO: dec = '0;
`endif
               default: ;
            endcase
         end
         OP_LW: begin
            dec.alu_src    = 1'b1;
            dec.mem_to_reg = 1'b1;
            dec.reg_write  = 1'b1;
            dec.alu_cont   = ALU_ADD;
         end
         OP_SW: begin
            dec.alu_src   = 1'b1;
            dec.mem_write = 1'b1;
            dec.alu_cont  = ALU_ADD;
         end
         OP_BEQ: begin
            dec.branch   = 1'b1;
            dec.alu_cont = ALU_SUB;
         end
         OP_ADDI: begin
            dec.alu_src   = 1'b1;
            dec.reg_write = 1'b1;
            dec.alu_cont  = ALU_ADD;
         end
         OP_J: dec.jump = 1'b1;
         OP_JAL: begin
            dec.jump      = 1'b1;
            dec.jal       = 1'b1;
            dec.reg_write = 1'b1;
         end
         default: ;
      endcase
   end

`ifdef MD_UNIT_EN
   logic md_start;

   assign md_start = (id_ex_q.ext_cont == EXT_MULT) ||
                     (id_ex_q.ext_cont == EXT_DIV);

   md_busy_ctr #(
      .LATENCY (MD_LATENCY)
   ) u_md_busy_ctr (
      .clk     (clk),
      .reset   (reset),
      .start_i (md_start),
      .busy_o  (md_busy)
   );

   assign md_stall = md_busy & (dec.ext_cont != EXT_NONE);
`else
   assign md_busy  = 1'b0;
   assign md_stall = 1'b0;
`endif

   assign stall_d    = hazard_stall | md_stall;
   assign jump_sel_d = dec.jump;

   always_comb begin
      id_ex_d = '0;
      if (!(stall_d || flush_e)) begin
         id_ex_d.alu_src    = dec.alu_src;
         id_ex_d.reg_dst    = dec.reg_dst;
         id_ex_d.jal        = dec.jal;
         id_ex_d.alu_cont   = dec.alu_cont;
         id_ex_d.ext_cont   = dec.ext_cont;
         id_ex_d.mem_write  = dec.mem_write;
         id_ex_d.reg_write  = dec.reg_write;
         id_ex_d.mem_to_reg = dec.mem_to_reg;
         id_ex_d.branch     = dec.branch;
      end
   end

   always_comb begin
      ex_mem_d.jal        = id_ex_q.jal;
      ex_mem_d.mem_write  = id_ex_q.mem_write;
      ex_mem_d.reg_write  = id_ex_q.reg_write;
      ex_mem_d.mem_to_reg = id_ex_q.mem_to_reg;
      mem_wb_d.jal        = ex_mem_q.jal;
      mem_wb_d.reg_write  = ex_mem_q.reg_write;
      mem_wb_d.mem_to_reg = ex_mem_q.mem_to_reg;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         id_ex_q  <= '0;
         ex_mem_q <= '0;
         mem_wb_q <= '0;
      end else begin
         id_ex_q  <= id_ex_d;
         ex_mem_q <= ex_mem_d;
         mem_wb_q <= mem_wb_d;
      end
   end

   assign pc_src_sel_e     = id_ex_q.branch & zero_e;
   assign flush_d          = pc_src_sel_e;
   assign alu_src_e        = id_ex_q.alu_src;
   assign reg_dst_sel_e    = id_ex_q.reg_dst;
   assign jal_sel_e        = id_ex_q.jal;
   assign alu_cont_e       = id_ex_q.alu_cont;
   assign ext_cont_e       = id_ex_q.ext_cont;
   assign mem_write_m      = ex_mem_q.mem_write;
   assign reg_write_m      = ex_mem_q.reg_write;
   assign mem_to_reg_sel_m = ex_mem_q.mem_to_reg;
   assign reg_write_w      = mem_wb_q.reg_write;
   assign mem_to_reg_sel_w = mem_wb_q.mem_to_reg;
   assign jal_sel_w        = mem_wb_q.jal;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit with a cycle-stamped scoreboard.
// Mult/div steps are compiled only when MD_UNIT_EN is defined.
module tb_pipe_ctrl_unit;

   localparam logic [5:0] NOP_OP = 6'b111111;
   localparam logic [5:0] O_R    = 6'b000000;
   localparam logic [5:0] O_LW   = 6'b100011;
   localparam logic [5:0] O_SW   = 6'b101011;
   localparam logic [5:0] O_BEQ  = 6'b000100;
   localparam logic [5:0] O_ADDI = 6'b001000;
   localparam logic [5:0] O_J    = 6'b000010;
   localparam logic [5:0] O_JAL  = 6'b000011;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op_d, funct_d;
   logic       hazard_stall, flush_e, zero_e;
   logic       stall_d, jump_sel_d, pc_src_sel_e, flush_d;
   logic       alu_src_e, reg_dst_sel_e, jal_sel_e;
   logic [2:0] alu_cont_e;
   logic [3:0] ext_cont_e;
   logic       mem_write_m, reg_write_m, mem_to_reg_sel_m;
   logic       reg_write_w, mem_to_reg_sel_w, jal_sel_w;
   logic       md_busy;

   pipe_ctrl_unit #(
      .ALU_CONT_W (3),
      .EXT_CONT_W (4),
      .MD_LATENCY (4)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .op_d             (op_d),
      .funct_d          (funct_d),
      .hazard_stall     (hazard_stall),
      .flush_e          (flush_e),
      .zero_e           (zero_e),
      .stall_d          (stall_d),
      .jump_sel_d       (jump_sel_d),
      .pc_src_sel_e     (pc_src_sel_e),
      .flush_d          (flush_d),
      .alu_src_e        (alu_src_e),
      .reg_dst_sel_e    (reg_dst_sel_e),
      .jal_sel_e        (jal_sel_e),
      .alu_cont_e       (alu_cont_e),
      .ext_cont_e       (ext_cont_e),
      .mem_write_m      (mem_write_m),
      .reg_write_m      (reg_write_m),
      .mem_to_reg_sel_m (mem_to_reg_sel_m),
      .reg_write_w      (reg_write_w),
      .mem_to_reg_sel_w (mem_to_reg_sel_w),
      .jal_sel_w        (jal_sel_w),
      .md_busy          (md_busy)
   );

   always #5 clk = ~clk;

   typedef enum int {
      S_STALL, S_JUMP, S_PCSRC, S_FLUSH, S_ALUSRC, S_REGDST, S_JALE,
      S_ALU, S_EXT, S_MW_M, S_RW_M, S_M2R_M, S_RW_W, S_M2R_W,
      S_JAL_W, S_BUSY, S_EXALL, S_MALL, S_WALL
   } sig_e;

   typedef struct {
      int          cyc;
      string       tag;
      sig_e        sig;
      logic [15:0] val;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errs   = 0;

   function automatic logic [15:0] obs(input sig_e s);
      case (s)
         S_STALL:  return 16'(stall_d);
         S_JUMP:   return 16'(jump_sel_d);
         S_PCSRC:  return 16'(pc_src_sel_e);
         S_FLUSH:  return 16'(flush_d);
         S_ALUSRC: return 16'(alu_src_e);
         S_REGDST: return 16'(reg_dst_sel_e);
         S_JALE:   return 16'(jal_sel_e);
         S_ALU:    return 16'(alu_cont_e);
         S_EXT:    return 16'(ext_cont_e);
         S_MW_M:   return 16'(mem_write_m);
         S_RW_M:   return 16'(reg_write_m);
         S_M2R_M:  return 16'(mem_to_reg_sel_m);
         S_RW_W:   return 16'(reg_write_w);
         S_M2R_W:  return 16'(mem_to_reg_sel_w);
         S_JAL_W:  return 16'(jal_sel_w);
         S_BUSY:   return 16'(md_busy);
         S_EXALL:  return 16'({alu_src_e, reg_dst_sel_e, jal_sel_e,
                                alu_cont_e, ext_cont_e});
         S_MALL:   return 16'({mem_write_m, reg_write_m, mem_to_reg_sel_m});
         S_WALL:   return 16'({reg_write_w, mem_to_reg_sel_w, jal_sel_w});
         default:  return 16'hffff;
      endcase
   endfunction

   task automatic push(input int off, input string tag,
                       input sig_e s, input logic [15:0] v);
      exp_t e;
      e.cyc = cyc + off;
      e.tag = tag;
      e.sig = s;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic drain_now();
      exp_t keep[$];
      logic [15:0] o;
      foreach (sb[i]) begin
         if (sb[i].cyc == cyc) begin
            o = obs(sb[i].sig);
            checks++;
            assert (o === sb[i].val) else begin
               errs++;
               $error("FAIL %s: observed=%0h expected=%0h",
                      sb[i].tag, o, sb[i].val);
            end
         end else begin
            keep.push_back(sb[i]);
         end
      end
      sb = keep;
   endtask

   task automatic step(input logic [5:0] op, input logic [5:0] fn,
                       input logic hs = 1'b0, input logic fe = 1'b0,
                       input logic z = 1'b0);
      op_d         = op;
      funct_d      = fn;
      hazard_stall = hs;
      flush_e      = fe;
      zero_e       = z;
      #1;
      drain_now();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic nops(input int n);
      for (int i = 0; i < n; i++) step(NOP_OP, 6'd0);
   endtask

   initial begin
      reset        = 1'b1;
      op_d         = NOP_OP;
      funct_d      = 6'd0;
      hazard_stall = 1'b0;
      flush_e      = 1'b0;
      zero_e       = 1'b0;
      #1;
      push(0, "rst_e", S_EXALL, 0);
      push(0, "rst_m", S_MALL, 0);
      push(0, "rst_w", S_WALL, 0);
      push(0, "rst_busy", S_BUSY, 0);
      push(0, "rst_stall", S_STALL, 0);
      drain_now();
      @(posedge clk);
      #1;
      reset = 1'b0;

      // lw through all stages
      push(1, "lw_e_src", S_ALUSRC, 1);
      push(1, "lw_e_alu", S_ALU, 3'b010);
      push(2, "lw_m_rw", S_RW_M, 1);
      push(2, "lw_m_m2r", S_M2R_M, 1);
      push(2, "lw_m_mw", S_MW_M, 0);
      push(3, "lw_w_rw", S_RW_W, 1);
      push(3, "lw_w_m2r", S_M2R_W, 1);
      step(O_LW, 6'd0);
      push(2, "sw_m_mw", S_MW_M, 1);
      push(2, "sw_m_rw", S_RW_M, 0);
      step(O_SW, 6'd0);
      nops(3);

      // data-hazard stall holding an add in ID
      push(0, "hs_stall", S_STALL, 1);
      push(1, "hs_bub1", S_EXALL, 0);
      step(O_R, 6'b100000, 1'b1);
      push(1, "hs_bub2", S_EXALL, 0);
      step(O_R, 6'b100000, 1'b1);
      push(0, "hs_free", S_STALL, 0);
      push(1, "add_alu", S_ALU, 3'b010);
      push(1, "add_rd", S_REGDST, 1);
      push(3, "add_w", S_RW_W, 1);
      step(O_R, 6'b100000);
      push(1, "sub_alu", S_ALU, 3'b110);
      step(O_R, 6'b100010);
      push(1, "and_alu", S_ALU, 3'b000);
      step(O_R, 6'b100100);
      push(1, "or_alu", S_ALU, 3'b001);
      step(O_R, 6'b100101);
      push(1, "slt_alu", S_ALU, 3'b111);
      step(O_R, 6'b101010);
      push(1, "unk_alu", S_ALU, 3'b010);
      step(O_R, 6'b111111);

      // branches
      push(1, "beq_alu", S_ALU, 3'b110);
      step(O_BEQ, 6'd0);
      push(0, "beqt_pc", S_PCSRC, 1);
      push(0, "beqt_fl", S_FLUSH, 1);
      step(NOP_OP, 6'd0, 1'b0, 1'b0, 1'b1);
      step(O_BEQ, 6'd0);
      push(0, "beqn_pc", S_PCSRC, 0);
      push(0, "beqn_fl", S_FLUSH, 0);
      step(NOP_OP, 6'd0);
      step(O_BEQ, 6'd0, 1'b0, 1'b1);
      push(0, "beqb_pc", S_PCSRC, 0);
      push(0, "beqb_e", S_EXALL, 0);
      step(NOP_OP, 6'd0, 1'b0, 1'b0, 1'b1);

      // jumps, addi, unknown opcode
      push(0, "j_sel", S_JUMP, 1);
      push(1, "j_e", S_EXALL, 0);
      step(O_J, 6'd0);
      push(0, "jal_sel", S_JUMP, 1);
      push(1, "jal_e", S_JALE, 1);
      push(3, "jal_w", S_JAL_W, 1);
      push(3, "jal_rw", S_RW_W, 1);
      step(O_JAL, 6'd0);
      push(1, "addi_src", S_ALUSRC, 1);
      push(1, "addi_alu", S_ALU, 3'b010);
      push(2, "addi_rw", S_RW_M, 1);
      step(O_ADDI, 6'd0);
      push(0, "unk_jmp", S_JUMP, 0);
      push(1, "unk_e", S_EXALL, 0);
      push(2, "unk_m", S_MALL, 0);
      step(6'b110001, 6'd0);
      nops(3);

`ifdef MD_UNIT_EN
      push(1, "mult_ext", S_EXT, 1);
      push(2, "mult_rw", S_RW_M, 0);
      step(O_R, 6'b011000);
      push(0, "mult_ex_busy", S_BUSY, 0);
      step(NOP_OP, 6'd0);
      for (int k = 0; k < 4; k++) begin
         push(0, "md_busy", S_BUSY, 1);
         push(0, "md_stall", S_STALL, 1);
         push(1, "md_bub", S_EXT, 0);
         step(O_R, 6'b010010);
      end
      push(0, "md_done", S_BUSY, 0);
      push(0, "md_nostall", S_STALL, 0);
      push(1, "mflo_ext", S_EXT, 4);
      step(O_R, 6'b010010);
      step(O_R, 6'b011000);
      push(0, "fw_stall", S_STALL, 0);
      push(1, "fw_ext", S_EXT, 3);
      step(O_R, 6'b010000);
      nops(6);
`else
      push(0, "nomd_stall", S_STALL, 0);
      push(1, "nomd_e", S_EXALL, 0);
      push(2, "nomd_rw", S_RW_M, 0);
      push(1, "nomd_busy", S_BUSY, 0);
      step(O_R, 6'b011000);
      push(1, "nomd_mfhi", S_EXALL, 0);
      push(2, "nomd_busy2", S_BUSY, 0);
      step(O_R, 6'b010000);
      nops(3);
`endif

      // asynchronous reset with lw in EX and addi in MEM
      step(O_ADDI, 6'd0);
      step(O_LW, 6'd0);
      push(0, "pre_e", S_ALUSRC, 1);
      push(0, "pre_m", S_RW_M, 1);
      drain_now();
      reset = 1'b1;
      #1;
      push(0, "arst_e", S_EXALL, 0);
      push(0, "arst_m", S_MALL, 0);
      push(0, "arst_w", S_WALL, 0);
      push(0, "arst_busy", S_BUSY, 0);
      drain_now();
      step(NOP_OP, 6'd0);
      reset = 1'b0;
      nops(4);

      foreach (sb[i]) begin
         checks++;
         errs++;
         $error("FAIL %s: never compared, due cycle %0d", sb[i].tag, sb[i].cyc);
      end
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
